// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared definitions for the ALU operation sequencer. It holds
//               the ALU opcode encodings, the reserved (illegal) opcode range,
//               the sequencer state encoding, and a helper that tests for a
//               reserved opcode.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    // ALU opcode encodings, as presented on alu_ctrl
    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0011,
        OP_SHR = 4'b0100,
        OP_SHL = 4'b0101,
        OP_ROR = 4'b0110,
        OP_ROL = 4'b0111,
        OP_MUL = 4'b1000,
        OP_DIV = 4'b1001,
        OP_NEG = 4'b1010,
        OP_NOT = 4'b1011
    } alu_op_e;

    // Reserved opcode range; these opcodes are never executed
    localparam logic [3:0] c_illegal_lo = 4'b1100;
    localparam logic [3:0] c_illegal_hi = 4'b1111;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_Y = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB_LO  = 3'd3,
        ST_WB_HI  = 3'd4
    } seq_state_e;

    // True when op falls inside the reserved range. The upper bound is tested
    // through an offset so the check stays valid if the range is ever narrowed.
    function automatic logic op_is_reserved(input logic [3:0] op);
        logic [3:0] w_offset;
        w_offset = op - c_illegal_lo;
        return (op >= c_illegal_lo) && (w_offset <= (c_illegal_hi - c_illegal_lo));
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_decode
// Description : Combinational opcode classifier for the ALU operation
//               sequencer.
//               Ports:
//                 i_op        [3:0] opcode to classify
//                 o_is_unary        single-source operation (neg, not)
//                 o_is_muldiv       double-width result (mul, div)
//                 o_is_legal        opcode may be executed
//               Config macro : ALU_SEQ_MULDIV_EN. When it is undefined,
//               mul/div are classed as illegal and o_is_muldiv is held low.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_decode (
    input  logic [3:0] i_op,
    output logic       o_is_unary,
    output logic       o_is_muldiv,
    output logic       o_is_legal
);
    import alu_seq_pkg::*;

    logic w_muldiv_code;

    always_comb begin
        w_muldiv_code = (i_op == OP_MUL) || (i_op == OP_DIV);
        o_is_unary    = (i_op == OP_NEG) || (i_op == OP_NOT);
`ifdef ALU_SEQ_MULDIV_EN
        o_is_muldiv   = w_muldiv_code;
        o_is_legal    = !op_is_reserved(i_op);
`else
        // Without a hi/lo register pair, mul/div cannot be written back
        o_is_muldiv   = 1'b0;
        o_is_legal    = !op_is_reserved(i_op) && !w_muldiv_code;
`endif
    end

endmodule
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_sequencer
// Description : Sequences one ALU operation at a time through the datapath
//               strobes: Y load, ALU execute into Z, then write-back of Z low
//               (and Z high for mul/div).
//               Ports:
//                 clk, clr_n (async active-low reset)
//                 req_valid/req_ready, req_op[3:0], req_ra/rb/rc[3:0]
//                 reg_sel[3:0], reg_out, reg_in
//                 y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in
//                 alu_ctrl[3:0], done, err, op_count[15:0]
//               Config macro : ALU_SEQ_MULDIV_EN enables mul/div sequencing
//               through the hi/lo write-back states.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
    parameter int REG_SIZE = 32
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [3:0]  req_ra,
    input  logic [3:0]  req_rb,
    input  logic [3:0]  req_rc,
    output logic [3:0]  reg_sel,
    output logic        reg_out,
    output logic        reg_in,
    output logic        y_in,
    output logic        z_in,
    output logic        zlow_out,
    output logic        zhigh_out,
    output logic        hi_in,
    output logic        lo_in,
    output logic [3:0]  alu_ctrl,
    output logic        done,
    output logic        err,
    output logic [15:0] op_count
);
    import alu_seq_pkg::*;

    // The datapath width does not affect any control strobe; this empty block
    // only marks a non-positive width as an unsupported configuration.
    generate
        if (REG_SIZE < 1) begin : g_reg_size_unsupported
        end
    endgenerate

    seq_state_e  r_state;
    seq_state_e  w_state_nxt;
    logic [3:0]  r_op;
    logic [3:0]  r_ra;
    logic [3:0]  r_rb;
    logic [3:0]  r_rc;
    logic        r_is_unary;
    logic        r_is_muldiv;
    logic        r_err;
    logic [15:0] r_op_count;

    logic        w_handshake;
    logic        w_dec_unary;
    logic        w_dec_muldiv;
    logic        w_dec_legal;

    alu_seq_decode u_decode (
        .i_op        (req_op),
        .o_is_unary  (w_dec_unary),
        .o_is_muldiv (w_dec_muldiv),
        .o_is_legal  (w_dec_legal)
    );

    // The cycle that reports an illegal opcode is not ready, so the error
    // pulse always precedes the next acceptance by one cycle, like done.
    assign req_ready   = (r_state == ST_IDLE) && !r_err;
    assign w_handshake = req_valid && req_ready;
    assign err         = r_err;
    assign op_count    = r_op_count;

    // State register, request capture, error pulse
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state     <= ST_IDLE;
            r_op        <= 4'd0;
            r_ra        <= 4'd0;
            r_rb        <= 4'd0;
            r_rc        <= 4'd0;
            r_is_unary  <= 1'b0;
            r_is_muldiv <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_handshake && !w_dec_legal;
            if (w_handshake) begin
                r_op        <= req_op;
                r_ra        <= req_ra;
                r_rb        <= req_rb;
                r_rc        <= req_rc;
                r_is_unary  <= w_dec_unary;
                r_is_muldiv <= w_dec_muldiv;
            end
        end
    end

    // Completed-operation counter, saturating
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_op_count <= 16'd0;
        end else if (done && (r_op_count != 16'hFFFF)) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    // Next state and datapath strobes
    always_comb begin
        w_state_nxt = r_state;
        reg_sel     = 4'd0;
        reg_out     = 1'b0;
        reg_in      = 1'b0;
        y_in        = 1'b0;
        z_in        = 1'b0;
        zlow_out    = 1'b0;
        zhigh_out   = 1'b0;
        hi_in       = 1'b0;
        lo_in       = 1'b0;
        alu_ctrl    = 4'd0;
        done        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Illegal opcodes stay in IDLE; r_err carries the report
                if (w_handshake && w_dec_legal) begin
                    w_state_nxt = w_dec_unary ? ST_EXEC : ST_LOAD_Y;
                end
            end
            ST_LOAD_Y: begin
                reg_sel     = r_rb;
                reg_out     = 1'b1;
                y_in        = 1'b1;
                w_state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                // Unary ops take their only operand from rb straight into the ALU
                reg_sel     = r_is_unary ? r_rb : r_rc;
                reg_out     = 1'b1;
                alu_ctrl    = r_op;
                z_in        = 1'b1;
                w_state_nxt = ST_WB_LO;
            end
            ST_WB_LO: begin
                zlow_out = 1'b1;
                if (r_is_muldiv) begin
                    lo_in       = 1'b1;
                    w_state_nxt = ST_WB_HI;
                end else begin
                    reg_sel     = r_ra;
                    reg_in      = 1'b1;
                    done        = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WB_HI: begin
`ifdef ALU_SEQ_MULDIV_EN
                zhigh_out = 1'b1;
                hi_in     = 1'b1;
                done      = 1'b1;
`endif
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_op_sequencer
// Description : Self-checking bench for alu_op_sequencer. Each request pushes
//               its expected per-cycle output vectors to a queue; the scenario
//               tasks pop and compare one vector per clock on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

`ifdef ALU_SEQ_MULDIV_EN
    localparam bit c_muldiv_en = 1'b1;
`else
    localparam bit c_muldiv_en = 1'b0;
`endif

    typedef struct packed {
        logic       ready;
        logic [3:0] sel;
        logic       rout;
        logic       rin;
        logic       y;
        logic       z;
        logic       zl;
        logic       zh;
        logic       hi;
        logic       lo;
        logic [3:0] ctrl;
        logic       done;
        logic       err;
    } obs_t;

    logic        clk;
    logic        clr_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [3:0]  req_ra;
    logic [3:0]  req_rb;
    logic [3:0]  req_rc;
    logic [3:0]  reg_sel;
    logic        reg_out;
    logic        reg_in;
    logic        y_in;
    logic        z_in;
    logic        zlow_out;
    logic        zhigh_out;
    logic        hi_in;
    logic        lo_in;
    logic [3:0]  alu_ctrl;
    logic        done;
    logic        err;
    logic [15:0] op_count;

    obs_t        obs;
    obs_t        exp_q[$];
    logic [15:0] model_count;
    int          n_vec;
    int          n_fail;

    alu_op_sequencer #(.REG_SIZE(32)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_ra    (req_ra),
        .req_rb    (req_rb),
        .req_rc    (req_rc),
        .reg_sel   (reg_sel),
        .reg_out   (reg_out),
        .reg_in    (reg_in),
        .y_in      (y_in),
        .z_in      (z_in),
        .zlow_out  (zlow_out),
        .zhigh_out (zhigh_out),
        .hi_in     (hi_in),
        .lo_in     (lo_in),
        .alu_ctrl  (alu_ctrl),
        .done      (done),
        .err       (err),
        .op_count  (op_count)
    );

    assign obs = {req_ready, reg_sel, reg_out, reg_in, y_in, z_in, zlow_out,
                  zhigh_out, hi_in, lo_in, alu_ctrl, done, err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard model: expected output vectors, one per cycle after the
    // handshake edge, ending with the idle cycle in which ready returns.
    task automatic push_expect(input logic [3:0] op, input logic [3:0] ra,
                               input logic [3:0] rb, input logic [3:0] rc);
        obs_t v;
        bit   unary;
        bit   muldiv;
        bit   legal;
        unary  = (op == 4'hA) || (op == 4'hB);
        muldiv = (op == 4'h8) || (op == 4'h9);
        legal  = (op <= 4'hB) && (c_muldiv_en || !muldiv);
        if (!legal) begin
            v = '0; v.err = 1'b1; exp_q.push_back(v);
        end else begin
            if (!unary) begin
                v = '0; v.sel = rb; v.rout = 1'b1; v.y = 1'b1; exp_q.push_back(v);
            end
            v = '0; v.sel = unary ? rb : rc; v.rout = 1'b1; v.ctrl = op; v.z = 1'b1;
            exp_q.push_back(v);
            v = '0; v.zl = 1'b1;
            if (muldiv) v.lo = 1'b1;
            else begin v.sel = ra; v.rin = 1'b1; v.done = 1'b1; end
            exp_q.push_back(v);
            if (muldiv) begin
                v = '0; v.zh = 1'b1; v.hi = 1'b1; v.done = 1'b1; exp_q.push_back(v);
            end
            if (model_count != 16'hFFFF) model_count = model_count + 16'd1;
        end
        v = '0; v.ready = 1'b1; exp_q.push_back(v);
    endtask

    // Present a request at the current falling edge and record its expectation
    task automatic send(input logic [3:0] op, input logic [3:0] ra,
                        input logic [3:0] rb, input logic [3:0] rc);
        req_valid = 1'b1;
        req_op    = op;
        req_ra    = ra;
        req_rb    = rb;
        req_rc    = rc;
        push_expect(op, ra, rb, rc);
    endtask

    task automatic test_reset();
        obs_t o;
        clr_n = 1'b0;
        #12;
        o = obs; o.ready = 1'b0;
        n_vec++;
        if (o !== obs_t'(0)) begin
            n_fail++; $display("FAIL reset_outputs: got=%h want=0", o);
        end
        n_vec++;
        if (op_count !== 16'd0) begin
            n_fail++; $display("FAIL reset_count: got=%0d want=0", op_count);
        end
        @(negedge clk);
        clr_n = 1'b1;
        #1;
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got=%b want=1", req_ready);
        end
        model_count = 16'd0;
        @(negedge clk);
    endtask

    task automatic test_add();
        obs_t e;
        send(4'h2, 4'd1, 4'd2, 4'd3);
        for (int k = 0; exp_q.size() > 0; k++) begin
            @(negedge clk);
            if (k == 0) req_valid = 1'b0;
            e = exp_q.pop_front(); n_vec++;
            if (obs !== e) begin
                n_fail++; $display("FAIL add[%0d]: got=%h want=%h", k, obs, e);
            end
        end
        n_vec++;
        if (op_count !== model_count) begin
            n_fail++; $display("FAIL add_count: got=%0d want=%0d", op_count, model_count);
        end
    endtask

    task automatic test_not();
        obs_t e;
        send(4'hB, 4'd4, 4'd5, 4'd9);
        for (int k = 0; exp_q.size() > 0; k++) begin
            @(negedge clk);
            if (k == 0) req_valid = 1'b0;
            e = exp_q.pop_front(); n_vec++;
            if (obs !== e) begin
                n_fail++; $display("FAIL not[%0d]: got=%h want=%h", k, obs, e);
            end
        end
        n_vec++;
        if (op_count !== model_count) begin
            n_fail++; $display("FAIL not_count: got=%0d want=%0d", op_count, model_count);
        end
    endtask

    task automatic test_mul();
        obs_t e;
        send(4'h8, 4'd6, 4'd7, 4'd8);
        for (int k = 0; exp_q.size() > 0; k++) begin
            @(negedge clk);
            if (k == 0) req_valid = 1'b0;
            e = exp_q.pop_front(); n_vec++;
            if (obs !== e) begin
                n_fail++; $display("FAIL mul[%0d]: got=%h want=%h", k, obs, e);
            end
        end
        n_vec++;
        if (op_count !== model_count) begin
            n_fail++; $display("FAIL mul_count: got=%0d want=%0d", op_count, model_count);
        end
    endtask

    task automatic test_illegal();
        obs_t e;
        logic [3:0] ops [3] = '{4'hE, 4'hC, 4'hF};
        for (int i = 0; i < 3; i++) begin
            send(ops[i], 4'd1, 4'd2, 4'd3);
            for (int k = 0; exp_q.size() > 0; k++) begin
                @(negedge clk);
                if (k == 0) req_valid = 1'b0;
                e = exp_q.pop_front(); n_vec++;
                if (obs !== e) begin
                    n_fail++; $display("FAIL illegal_%h[%0d]: got=%h want=%h", ops[i], k, obs, e);
                end
            end
            n_vec++;
            if (op_count !== model_count) begin
                n_fail++; $display("FAIL illegal_count: got=%0d want=%0d", op_count, model_count);
            end
        end
    endtask

    task automatic test_ops();
        obs_t e;
        logic [3:0] ops [9] = '{4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hA, 4'h9};
        logic [3:0] ra, rb, rc;
        for (int i = 0; i < 9; i++) begin
            ra = 4'($urandom_range(15));
            rb = 4'($urandom_range(15));
            rc = 4'($urandom_range(15));
            send(ops[i], ra, rb, rc);
            for (int k = 0; exp_q.size() > 0; k++) begin
                @(negedge clk);
                if (k == 0) req_valid = 1'b0;
                e = exp_q.pop_front(); n_vec++;
                if (obs !== e) begin
                    n_fail++; $display("FAIL op_%h[%0d]: got=%h want=%h", ops[i], k, obs, e);
                end
            end
            n_vec++;
            if (op_count !== model_count) begin
                n_fail++; $display("FAIL op_%h_count: got=%0d want=%0d", ops[i], op_count, model_count);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        obs_t e;
        obs_t o;
        send(4'h2, 4'd6, 4'd7, 4'd8);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (k == 0) req_valid = 1'b0;
            e = exp_q.pop_front(); n_vec++;
            if (obs !== e) begin
                n_fail++; $display("FAIL midrst_pre[%0d]: got=%h want=%h", k, obs, e);
            end
        end
        // now in EXEC; pull reset between clock edges
        #2 clr_n = 1'b0;
        #1;
        exp_q.delete();
        model_count = 16'd0;
        o = obs; o.ready = 1'b0;
        n_vec++;
        if (o !== obs_t'(0)) begin
            n_fail++; $display("FAIL midrst_strobes: got=%h want=0", o);
        end
        n_vec++;
        if (op_count !== 16'd0) begin
            n_fail++; $display("FAIL midrst_count: got=%0d want=0", op_count);
        end
        @(negedge clk);
        o = obs; o.ready = 1'b0;
        n_vec++;
        if (o !== obs_t'(0)) begin
            n_fail++; $display("FAIL midrst_hold: got=%h want=0", o);
        end
        clr_n = 1'b1;
        @(negedge clk);
        e = '0; e.ready = 1'b1;
        n_vec++;
        if (obs !== e) begin
            n_fail++; $display("FAIL midrst_idle: got=%h want=%h", obs, e);
        end
        send(4'h2, 4'd1, 4'd2, 4'd3);
        for (int k = 0; exp_q.size() > 0; k++) begin
            @(negedge clk);
            if (k == 0) req_valid = 1'b0;
            e = exp_q.pop_front(); n_vec++;
            if (obs !== e) begin
                n_fail++; $display("FAIL midrst_add[%0d]: got=%h want=%h", k, obs, e);
            end
        end
        n_vec++;
        if (op_count !== model_count) begin
            n_fail++; $display("FAIL midrst_add_count: got=%0d want=%0d", op_count, model_count);
        end
    endtask

    task automatic test_back_to_back();
        obs_t e;
        // first op: add; second op: rol, presented while the first is busy
        send(4'h2, 4'd9, 4'd10, 4'd11);
        push_expect(4'h7, 4'd12, 4'd13, 4'd14);
        for (int k = 0; exp_q.size() > 0; k++) begin
            @(negedge clk);
            e = exp_q.pop_front(); n_vec++;
            if (obs !== e) begin
                n_fail++; $display("FAIL b2b[%0d]: got=%h want=%h", k, obs, e);
            end
            case (k)
                0: begin req_op = 4'h7; req_ra = 4'd12; req_rb = 4'd13; req_rc = 4'd14; end
                1: req_valid = 1'b0;
                2: req_valid = 1'b1;
                4: req_valid = 1'b0;
                default: ;
            endcase
        end
        n_vec++;
        if (op_count !== model_count) begin
            n_fail++; $display("FAIL b2b_count: got=%0d want=%0d", op_count, model_count);
        end
    endtask

    initial begin
        n_vec       = 0;
        n_fail      = 0;
        model_count = 16'd0;
        clr_n       = 1'b0;
        req_valid   = 1'b0;
        req_op      = 4'd0;
        req_ra      = 4'd0;
        req_rb      = 4'd0;
        req_rc      = 4'd0;
        test_reset();
        test_add();
        test_not();
        test_mul();
        test_illegal();
        test_ops();
        test_reset_mid_op();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish by 100000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
